// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width; WIDTH >= 2 always yields at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_d;
    logic cell_bout;
    logic last_bit;

    full_subtractor_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Partial result builds in res_q so diff_q holds the previous answer until completion.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                br_d   = cell_bout;
                if (last_bit) begin
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = br_q ^ cell_bout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor (WIDTH = 8) against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int u;
        int s;
        logic [7:0] d;
        u = int'(x) - int'(y) - int'(c);
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
        d = u[7:0];
        return {(s < -128) || (s > 127), u < 0, d};
    endfunction

    function automatic logic cur_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output logic [7:0] od, output logic obo, output logic oov,
                         output int lat, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!out_valid) ok = 1'b0;
        od  = diff;
        obo = bout;
        oov = cur_ovf();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (diff !== 8'h00 || bout !== 1'b0 || cur_ovf() !== 1'b0)
            $display("FAIL reset_out: diff=%h bout=%b ovf=%b want 00/0/0", diff, bout, cur_ovf());
        else pass_cnt++;
    endtask

    task automatic check_op(input string name, input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                            input bit check_lat);
        logic [7:0] d; logic bo, ov; int lat; bit ok; logic [9:0] e;
        e = ref_sub(ia, ib, ibin);
        do_op(ia, ib, ibin, d, bo, ov, lat, ok);
        chk_cnt++;
        if (!ok) $display("FAIL %s_timeout: handshake timed out", name);
        else pass_cnt++;
        chk_cnt++;
        if (d !== e[7:0] || bo !== e[8])
            $display("FAIL %s: a=%h b=%h bin=%b diff=%h bout=%b want %h/%b", name, ia, ib, ibin, d, bo, e[7:0], e[8]);
        else pass_cnt++;
`ifdef SERIAL_SUB_OVF_EN
        chk_cnt++;
        if (ov !== e[9]) $display("FAIL %s_ovf: a=%h b=%h bin=%b ovf=%b want %b", name, ia, ib, ibin, ov, e[9]);
        else pass_cnt++;
`endif
        if (check_lat) begin
            chk_cnt++;
            if (lat != W) $display("FAIL %s_latency: got %0d want %0d", name, lat, W);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        check_op("basic", 8'h35, 8'h12, 1'b0, 1'b1);
    endtask

    task automatic test_underflow();
        check_op("underflow", 8'h00, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_signed_ovf();
        check_op("signed_ovf", 8'h80, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            check_op("random", 8'($urandom), 8'($urandom), 1'($urandom), i < 4);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        logic       oc [3];
        logic [9:0] e;
        int n;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        @(negedge clk);
        a = oa[0]; b = ob[0]; bin = oc[0]; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc = 1;
            if (i < 2) begin a = oa[i+1]; b = ob[i+1]; bin = oc[i+1]; end
            else in_valid = 1'b0;
            while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
            e = ref_sub(oa[i], ob[i], oc[i]);
            chk_cnt++;
            if (diff !== e[7:0] || bout !== e[8])
                $display("FAIL b2b_result: op%0d diff=%h bout=%b want %h/%b", i, diff, bout, e[7:0], e[8]);
            else pass_cnt++;
            while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
            chk_cnt++;
            if (cyc != W + 2) $display("FAIL b2b_interval: op%0d got %0d want %0d", i, cyc, W + 2);
            else pass_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [9:0] e0;
        logic [9:0] e1;
        int n;
        int bad;
        int lat;
        e0 = ref_sub(8'h9C, 8'h47, 1'b1);
        e1 = ref_sub(8'h10, 8'h20, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        a = 8'h9C; b = 8'h47; bin = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk_cnt++;
        if (!out_valid || diff !== e0[7:0] || bout !== e0[8])
            $display("FAIL bp_first: out_valid=%b diff=%h bout=%b want 1/%h/%b", out_valid, diff, bout, e0[7:0], e0[8]);
        else pass_cnt++;
        a = 8'h10; b = 8'h20; bin = 1'b0; in_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e0[7:0] || bout !== e0[8]) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL bp_hold: %0d stalled cycles disturbed, want 0", bad);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== e0[7:0])
            $display("FAIL bp_release: in_ready=%b out_valid=%b diff=%h want 1/0/%h", in_ready, out_valid, diff, e0[7:0]);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_accept: in_ready=%b want 0", in_ready);
        else pass_cnt++;
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk_cnt++;
        if (lat != W || diff !== e1[7:0] || bout !== e1[8])
            $display("FAIL bp_second: lat=%0d diff=%h bout=%b want %0d/%h/%b", lat, diff, bout, W, e1[7:0], e1[8]);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        out_ready = 1'b1;
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (diff !== 8'h00 || bout !== 1'b0 || cur_ovf() !== 1'b0)
            $display("FAIL midrst_out: diff=%h bout=%b ovf=%b want 00/0/0", diff, bout, cur_ovf());
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL midrst_no_valid: out_valid seen %0d cycles, want 0", bad);
        else pass_cnt++;
        check_op("after_rst", 8'hFF, 8'hFF, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_signed_ovf();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor computing diff = a − b − bin over WIDTH clock cycles, LSB first, using a single full-subtractor cell and a registered borrow. Generalises the combinational 1-bit full subtractor to arbitrary operand width with valid/ready handshakes on both sides. Sits in the arithmetic datapath library as the area-minimal subtractor for paths that can tolerate multi-cycle latency.

## Interface

- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands present on a, b, bin.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in applied at bit 0.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  out  1  final borrow; 1 iff unsigned a < b + bin.
- ovf  out  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. When in_valid && in_ready at an edge, load a, b into shift registers, load bin into the borrow register, clear the bit counter, and go to BUSY.
- BUSY: each cycle, process bit i = counter.
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d_i into the MSB of the diff register (right shift); shift a and b right.
  - When counter == WIDTH−1, latch bout = br_next and go to DONE.
- DONE: out_valid = 1; diff, bout and ovf are stable. On out_valid && out_ready go to IDLE.
- in_valid is ignored outside IDLE. The producer holds its operands until it sees in_ready.
- diff, bout and ovf keep their last result in IDLE, until the next completion or a reset.
- Counter width is $clog2(WIDTH). The counter does not wrap; it is cleared on each accept.
- Reset, including mid-operation: state = IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, counter = 0, borrow = 0. The aborted operation produces no output.

## Timing

- Accept at edge k. BUSY occupies edges k+1 … k+WIDTH. out_valid rises after edge k+WIDTH.
- Latency from accept to out_valid is WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles: 1 cycle in IDLE, WIDTH cycles in BUSY, 1 cycle in DONE with out_ready already high.
- in_ready and out_valid are decoded directly from the state register; there is no combinational path from inputs to outputs.
- out_ready held low stalls the block in DONE indefinitely with all outputs held.

## Configuration

- SERIAL_SUB_OVF_EN defined:
  - An ovf output and register are present.
  - At the MSB step, ovf = (borrow into the MSB) ^ (borrow out of the MSB).
  - ovf is valid with out_valid and resets to 0.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no ovf logic. All other behaviour is identical.

## Structure

- serial_subtractor_pkg contains:
  - the state_t enum (IDLE, BUSY, DONE);
  - the function for counter width, $clog2(WIDTH).
- Sub-module full_subtractor_cell is a purely combinational 1-bit cell (a, b, bin → d, bout) instantiated once. It is reusable elsewhere in the library.

## Test plan

All scenarios use WIDTH = 8.

- Reset check: release rst → in_ready = 1, out_valid = 0, diff = 0x00, bout = 0, ovf = 0.
- Basic operation: a = 0x35, b = 0x12, bin = 0 → diff = 0x23, bout = 0. out_valid rises exactly 8 cycles after the accept edge.
- Unsigned underflow: a = 0x00, b = 0x01, bin = 0 → diff = 0xFF, bout = 1, ovf = 0.
- Signed overflow (SERIAL_SUB_OVF_EN defined): a = 0x80, b = 0x01, bin = 0 → diff = 0x7F, bout = 0, ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while driving in_valid with new operands.
  - Required: diff and bout held, in_ready = 0, new operands not taken.
  - Raise out_ready → IDLE on the next cycle, after which the new operands are accepted.
- Reset mid-operation: assert rst in the 3rd BUSY cycle → IDLE immediately, with no out_valid pulse. Then run a = 0xFF, b = 0xFF, bin = 1 → diff = 0xFF, bout = 1, ovf = 0.
